ctrl_seq: RTL and testbench

- Controller-sequencer for the 4-bit bus machine.
- Issues every control strobe that the program counter, memory address register, RAM, instruction register, accumulator, B register, adder/subtractor and output register respond to.
- Runs a one-hot ring counter through fetch states T1–T3 and execute states T4–T6, and decodes the instruction register's opcode nibble during execute.
- Is the initiator side of the program counter's Cp/Ep interface and owns the halt condition.

---
 rtl/ctrl_seq.sv | 145 ++++++++++++++
 tb/tb_ctrl_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Controller-sequencer for the 4-bit bus machine: one-hot T1-T6 ring counter plus strobe decode.
// Optional macro CTRL_SEQ_EARLY_RET_EN returns the ring to T1 right after the last working state.
module ctrl_seq (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic [5:0] t_state,
    output logic       hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tState_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    tState_e r_state;
    tState_e w_nextState;
    logic    r_halted;
    logic    w_enterHalt;
    logic    w_halt;

    assign w_enterHalt = (r_state == T4) && (opcode == OP_HLT);
    assign w_halt      = r_halted || w_enterHalt;

    // Falling-edge state update keeps strobes settled before the rising edge that loads the bus registers.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= T1;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_halted <= w_halt;
        end
    end

`ifdef CTRL_SEQ_EARLY_RET_EN
    logic w_needsT5;
    logic w_needsT6;

    assign w_needsT5 = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
    assign w_needsT6 = (opcode == OP_ADD) || (opcode == OP_SUB);
`endif

    always_comb begin
        w_nextState = T1;
        if (w_halt) begin
            w_nextState = T4;
        end else begin
            case (r_state)
                T1: w_nextState = T2;
                T2: w_nextState = T3;
                T3: w_nextState = T4;
`ifdef CTRL_SEQ_EARLY_RET_EN
                T4: w_nextState = w_needsT5 ? T5 : T1;
                T5: w_nextState = w_needsT6 ? T6 : T1;
`else
                T4: w_nextState = T5;
                T5: w_nextState = T6;
`endif
                T6: w_nextState = T1;
                default: w_nextState = T1;
            endcase
        end
    end

    // Strobes are forced low during reset and halt, otherwise decoded from state and opcode.
    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Lm = 1'b0;
        CE = 1'b0;
        Li = 1'b0;
        Ei = 1'b0;
        La = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        Lb = 1'b0;
        Lo = 1'b0;
        t_state = r_state;
        hlt = clr && w_halt;
        if (clr && !w_halt) begin
            case (r_state)
                T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                T2: Cp = 1'b1;
                T3: begin
                    CE = 1'b1;
                    Li = 1'b1;
                end
                T4: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        CE = 1'b1;
                        La = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        CE = 1'b1;
                        Lb = 1'b1;
                    end
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        Eu = 1'b1;
                        La = 1'b1;
                        Su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq: reset, each instruction class, halt freeze and a short program.
module tb_ctrl_seq;

    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] CE = 12'h100;
    localparam logic [11:0] LI = 12'h080;
    localparam logic [11:0] EI = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

    logic       clk;
    logic       clr;
    logic [3:0] opcode;
    logic       Cp, Ep, Lm, CE_o, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
    logic [5:0] t_state;
    logic       hlt;
    logic [11:0] wordObs;
    logic [4:0]  drivers;

    int checkCount = 0;
    int passCount  = 0;

    ctrl_seq dut (
        .clk(clk), .clr(clr), .opcode(opcode),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE_o), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
        .t_state(t_state), .hlt(hlt)
    );

    assign wordObs = {Cp, Ep, Lm, CE_o, Li, Ei, La, Ea, Su, Eu, Lb, Lo};
    assign drivers = {Ep, CE_o, Ei, Ea, Eu};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Hand-written control word table, index 0..5 = T1..T6.
    function automatic logic [11:0] expWord(input int s, input logic [3:0] op);
        case (s)
            0: return EP | LM;
            1: return CP;
            2: return CE | LI;
            3: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? (EI | LM) : (op == 4'hE) ? (EA | LO) : 12'h000;
            4: return (op == 4'h0) ? (CE | LA) : (op == 4'h1 || op == 4'h2) ? (CE | LB) : 12'h000;
            5: return (op == 4'h1) ? (EU | LA) : (op == 4'h2) ? (EU | LA | SU) : 12'h000;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic int stIdx(input logic [5:0] st);
        case (st)
            6'b000001: return 0;
            6'b000010: return 1;
            6'b000100: return 2;
            6'b001000: return 3;
            6'b010000: return 4;
            6'b100000: return 5;
            default:   return -1;
        endcase
    endfunction

    function automatic int instrLen(input logic [3:0] op);
`ifdef CTRL_SEQ_EARLY_RET_EN
        if (op == 4'h1 || op == 4'h2) return 6;
        if (op == 4'h0) return 5;
        return 4;
`else
        return (op == 4'hF) ? 6 : 6;
`endif
    endfunction

    // Runs one full instruction starting in the low half of T1, ending in the low half of the next T1.
    task automatic applyStimulus(input logic [3:0] op);
        logic [5:0] expSt;
        for (int s = 0; s < instrLen(op); s++) begin
            if (s == 2) opcode = op;
            @(posedge clk); #1;
            expSt = 6'b000001 << s;
            checkOutput($sformatf("op%0h_T%0d_state", op, s + 1), t_state, expSt);
            checkOutput($sformatf("op%0h_T%0d_word", op, s + 1), wordObs, expWord(s, op));
            checkOutput($sformatf("op%0h_T%0d_bus", op, s + 1), ($countones(drivers) <= 1), 1);
            @(negedge clk); #1;
        end
        checkOutput($sformatf("op%0h_return", op), t_state, 6'b000001);
    endtask

    task automatic resetTest();
        @(negedge clk); #1;
        checkOutput("rst_state", t_state, 6'b000001);
        checkOutput("rst_word", wordObs, 12'h000);
        checkOutput("rst_hlt", hlt, 0);
        #1 clr = 1'b1;
        #1;
        checkOutput("rel_T1_word", wordObs, EP | LM);
        @(negedge clk); #1;
        checkOutput("rel_T2_state", t_state, 6'b000010);
        checkOutput("rel_T2_word", wordObs, CP);
        @(negedge clk); #1;
        opcode = 4'h1;
        @(negedge clk); #1;
        checkOutput("add_T4_word", wordObs, EI | LM);
        @(negedge clk); #1;
        checkOutput("add_T5_word", wordObs, CE | LB);
        clr = 1'b0;
        #1;
        checkOutput("midrst_state", t_state, 6'b000001);
        checkOutput("midrst_word", wordObs, 12'h000);
        checkOutput("midrst_hlt", hlt, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d_state", i), t_state, 6'b000001);
            checkOutput($sformatf("hold%0d_word", i), wordObs, 12'h000);
        end
        @(negedge clk); #2;
        clr = 1'b1;
        #1;
        checkOutput("rel2_T1_word", wordObs, EP | LM);
        @(negedge clk); #1;
        checkOutput("rel2_T2_state", t_state, 6'b000010);
        checkOutput("rel2_T2_word", wordObs, CP);
        clr = 1'b0; #1; clr = 1'b1; #1;
    endtask

    task automatic haltTest();
        for (int s = 0; s < 3; s++) begin
            if (s == 2) opcode = 4'hF;
            @(posedge clk); #1;
            checkOutput($sformatf("hltfetch_T%0d", s + 1), t_state, 6'b000001 << s);
            @(negedge clk); #1;
        end
        checkOutput("hlt_T4_state", t_state, 6'b001000);
        checkOutput("hlt_T4_hlt", hlt, 1);
        checkOutput("hlt_T4_word", wordObs, 12'h000);
        @(negedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            opcode = (i % 2 == 0) ? 4'h0 : 4'hE;
            @(posedge clk); #1;
            checkOutput($sformatf("frz%0d_state", i), t_state, 6'b001000);
            checkOutput($sformatf("frz%0d_hlt", i), hlt, 1);
            checkOutput($sformatf("frz%0d_word", i), wordObs, 12'h000);
            @(negedge clk); #1;
        end
        clr = 1'b0;
        #1;
        checkOutput("unhlt_hlt", hlt, 0);
        checkOutput("unhlt_state", t_state, 6'b000001);
        clr = 1'b1;
        #1;
        checkOutput("unhlt_word", wordObs, EP | LM);
    endtask

    task automatic programTest();
        logic [3:0] prog [0:4];
        int idx = 0;
        int cpCount = 0;
        int hltStart = -1;
        int expCycles;
        logic done = 1'b0;
        prog[0] = 4'h0; prog[1] = 4'h1; prog[2] = 4'h2; prog[3] = 4'hE; prog[4] = 4'hF;
        expCycles = instrLen(4'h0) + instrLen(4'h1) + instrLen(4'h2) + instrLen(4'hE);
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk); #1;
            if (t_state == 6'b000001 && n > 0 && idx < 4) begin
                idx++;
                if (idx == 4) hltStart = n;
            end
            if (t_state == 6'b000100) opcode = prog[idx];
            if (Cp) cpCount++;
            checkOutput($sformatf("prog%0d_word", n), wordObs, expWord(stIdx(t_state), prog[idx]));
            checkOutput($sformatf("prog%0d_bus", n), ($countones(drivers) <= 1), 1);
            if (hlt) done = 1'b1;
        end
        checkOutput("prog_halted", done, 1);
        checkOutput("prog_hltState", t_state, 6'b001000);
        checkOutput("prog_cpPulses", cpCount, 5);
        checkOutput("prog_cycles", hltStart, expCycles);
    endtask

    initial begin
        clr = 1'b0;
        opcode = 4'h0;
        resetTest();
        applyStimulus(4'h0);
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'hE);
        applyStimulus(4'h5);
        haltTest();
        @(negedge clk); #1;
        clr = 1'b0; #1; clr = 1'b1; #1;
        programTest();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
